muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit that sits directly upstream of the register file write port.
//  - Takes operand values read from the register file (RD1/RD2) and the destination index from decode.
//  - Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
//  - Returns the result as a one-cycle write request (result/wb_addr/wb_en -> WD3/A3/RegWrite).
// PARAMETERS
//  XLEN   32             operand/result width; only 32 is supported
//  CNT_W  $clog2(XLEN)+1 iteration counter width (derived, not overridable)
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     reset, asynchronous, active-high
//  start    in   1     request; sampled only in IDLE
//  kill     in   1     synchronous abort (pipeline flush); drops any in-flight op
//  funct3   in   3     RV32M op: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  rs1_val  in   32    operand A (dividend / multiplicand)
//  rs2_val  in   32    operand B (divisor / multiplier)
//  rd_addr  in   5     destination register index
//  busy     out  1     high whenever state != IDLE
//  done     out  1     one-cycle pulse; result valid
//  result   out  32    result; held until next done
//  wb_addr  out  5     captured rd_addr; held
//  wb_en    out  1     register-file write strobe = done & (wb_addr != 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, wb_en, result, wb_addr = 0; counter and datapath regs cleared.
//  States and transitions:
//  - IDLE: start&!kill -> capture funct3, operands, rd_addr.
//    - Go to DONE on a fast path; otherwise compute magnitudes and go to CALC with count=0.
//  - CALC: one iteration per edge, XLEN iterations, then FIX.
//    - Mul: shift-add into a 64-bit product.
//    - Div: restoring shift-subtract producing quotient and remainder.
//  - FIX: apply sign correction and select the 32-bit result; register it; go to DONE.
//  - DONE: done=1 for this cycle only; -> IDLE unconditionally.
//  Latency: normal op, done is high after 1+XLEN+1 = 34 edges counted from the accepting edge.
//    Fast path: done is high after 1 edge.
//  Fast paths (div ops only):
//  - Divisor 0: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = rs1_val.
//  - Signed overflow (DIV/REM, rs1=32'h8000_0000, rs2=32'hFFFF_FFFF): DIV = 32'h8000_0000, REM = 0.
//  Sign rules:
//  - MUL: low 32 bits.
//  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: unsigned. All return high 32 bits.
//  - Signed ops: quotient is negated iff operand signs differ; remainder takes the sign of the dividend.
//  Handshake:
//  - start is ignored while busy, including in DONE; no queueing.
//  - Upstream must hold operands stable only on the accepting edge.
//  - The stall signal to the pipeline is busy | start.
//  kill:
//  - Any state -> IDLE on the next edge; done and wb_en are not produced.
//  - result and wb_addr keep their prior values.
//  - kill has priority over start in IDLE.
//  rst mid-operation: immediate return to reset values; no write is ever issued.
//  x0: rd_addr=0 still runs to completion and pulses done, but wb_en stays 0.
// STRUCTURE
//  Package muldiv_pkg:
//  - typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t
//  - localparams for the 8 funct3 encodings
//  - helper is_div(funct3) = funct3[2]
//  Sub-module muldiv_step (combinational): one iteration.
//  - Mul: conditional add of multiplicand plus shift.
//  - Div: trial subtract plus shift.
//  - Instantiated once; muldiv_unit holds the FSM, counter, operand registers and sign fix.
// TESTING
//  MUL 7 x -3, rd=5 -> done after 34 edges; result=32'hFFFF_FFEB; wb_en=1, wb_addr=5 for 1 cycle.
//  MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFE; MULH same operands -> 0.
//  DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIVU 5/0 -> 32'hFFFF_FFFF and REM 5/0 -> 5, done after 1 edge.
//    DIV 32'h8000_0000/-1 -> 32'h8000_0000.
//  kill at CALC iteration 10 -> IDLE next edge, no done/wb_en.
//    New start accepted on the following edge completes correctly.
//  rst pulse during FIX; rd_addr=0 op; start pulse while busy.
//  - Reset case: all outputs 0.
//  - x0 case: done=1, wb_en=0.
//  - Busy case: the second request is dropped; exactly one done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types, funct3 encodings and decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Divide family is the upper half of the funct3 space.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Operand A is treated as two's complement for these ops.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Operand B is treated as two's complement for these ops.
  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared multiply/divide datapath.
// acc holds {hi, lo}: for multiply hi is the partial product and lo the remaining
// multiplier bits; for divide hi is the partial remainder and lo the dividend/quotient.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + ({1'b0, opnd_i} & {(XLEN+1){acc_i[0]}});
    shifted = acc_i[2*XLEN-1:XLEN-1];
    trial   = shifted - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!trial[XLEN]) begin
        acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic              done_q, done_d;
  logic              wb_en_q, wb_en_d;
  logic              busy_q, busy_d;

  logic [2*XLEN-1:0] step_acc;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              div_by_zero, div_ovf;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  // Operand magnitudes, fast-path detection and final sign correction.
  always_comb begin
    a_neg       = rs1_signed(funct3) & rs1_val[XLEN-1];
    b_neg       = rs2_signed(funct3) & rs2_val[XLEN-1];
    a_mag       = a_neg ? (~rs1_val + XLEN'(1)) : rs1_val;
    b_mag       = b_neg ? (~rs2_val + XLEN'(1)) : rs2_val;
    div_by_zero = is_div(funct3) && (rs2_val == '0);
    div_ovf     = is_div(funct3) && !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
    prod_fix    = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    quo_fix     = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem_fix     = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1)) : acc_q[2*XLEN-1:XLEN];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d = funct3;
          rd_d = rd_addr;
          if (div_by_zero || div_ovf) begin
            // Architecturally defined results that need no iteration.
            if (div_by_zero) begin
              result_d = funct3[1] ? rs1_val : '1;
            end else begin
              result_d = funct3[1] ? '0 : MIN_NEG;
            end
            state_d   = DONE;
            done_d    = 1'b1;
            wb_addr_d = rd_addr;
            wb_en_d   = (rd_addr != 5'd0);
          end else begin
            state_d   = CALC;
            cnt_d     = '0;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (is_div(funct3)) begin
              acc_d  = {{XLEN{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{XLEN{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        case (op_q)
          F3_MUL:                       result_d = prod_fix[XLEN-1:0];
          F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          F3_DIV, F3_DIVU:              result_d = quo_fix;
          default:                      result_d = rem_fix;
        endcase
        state_d   = DONE;
        done_d    = 1'b1;
        wb_addr_d = rd_q;
        wb_en_d   = (rd_q != 5'd0);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush drops the op without touching the visible write-port values.
    if (kill) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      wb_en_d   = 1'b0;
      result_d  = result_q;
      wb_addr_d = wb_addr_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;
  assign wb_en   = wb_en_q;

endmodule
